keccak_stream_adapter: RTL and testbench
========================================

Name: keccak_stream_adapter

Overview:
- Upstream feeder for the three-stage SHAKE keccak core.
- Accepts one command (mode, output length, message length) and a 32-bit message beat stream.
- Emits the core's 64-bit word stream: two header words, then packed, zero-masked message words.
- Drives the core's active-low valid and honours its active-high ready.

Parameters:
- IN_W, 32, upstream beat width in bits; fixed relation W = 2*IN_W.
- W, 64, core word width; must match keccak_pkg w.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  adapter accepts command
- cmd_mode  input  2  operation mode, passed to header
- cmd_out_bits  input  32  requested output length in bits
- cmd_in_bytes  input  32  message length in bytes
- s_valid  input  1  message beat present
- s_ready  output  1  adapter accepts beat
- s_data  input  IN_W  message beat; byte 0 in bits [7:0]
- s_last  input  1  final beat of message
- core_valid_n  output  1  active-low word valid to core
- core_ready  input  1  core ready (active-high)
- core_data  output  W  word to core
- busy  output  1  high from command accept until final word transfers
- err  output  1  sticky length mismatch flag, cleared on next command accept

Behaviour:
- Reset (rst=0, async): state IDLE; cmd_ready=1, s_ready=0, core_valid_n=1, core_data=0, busy=0, err=0; all counters 0.
- Core transfer: a word moves on a rising edge with core_valid_n=0 and core_ready=1. core_data is stable while core_valid_n=0 and core_ready=0.
- Upstream transfers: on edges with valid&ready.
- FSM IDLE: cmd_ready=1. On cmd accept:
  - latch fields; words_left=ceil(in_bytes/8); beats_left=ceil(in_bytes/4); clear err; busy=1; go HDR0.
- HDR0: core_data={cmd_mode, 30'b0, cmd_out_bits}; valid next cycle after accept (1-cycle latency); on transfer go HDR1.
- HDR1: core_data={29'b0, in_bytes, 3'b0}, i.e. message length in bits, 35 significant bits. On transfer go DATA, or DONE if in_bytes=0.
- DATA: s_ready=1 while the pack register is not full and beats_left>0.
  - First beat of a word goes to [31:0], second to [63:32].
  - Word is presented when both halves are filled or the message's final beat is taken.
  - Final word: bytes at index >= in_bytes are forced to 0, regardless of s_data.
  - No new beat is accepted while a full word awaits core_ready; no bubble between back-to-back words when both sides are ready.
  - After the last word transfers, go DONE.
- DONE: busy=0 one cycle later, return to IDLE; cmd_ready=1 again.
- Count rules: counters are 32 bits; in_bytes=0xFFFFFFFF is legal (beats_left=0x40000000).
- Simultaneous cmd_valid with busy=1: not accepted (cmd_ready=0).
- core_ready deasserted mid-header: state and data hold indefinitely.
- Reset mid-message: immediate return to reset values; partially sent message abandoned; core reset by the same rst.

Optional Feature:
- Macro: KECCAK_ADAPTER_LEN_CHECK_EN.
- Defined:
  - s_last asserted before beats_left reaches 1: remaining bytes are zero-filled, words still emitted, err=1.
  - beats_left reaches 0 without s_last: further beats are accepted and discarded until s_last, err=1.
- Undefined: s_last is ignored, length comes from cmd_in_bytes only, err tied 0, no discard phase.

Test Plan:
- cmd mode=2'b01, out_bits=256, in_bytes=0, core_ready=1 -> words 0x4000000000000100, 0x0, then idle; busy high 3 cycles after accept.
- in_bytes=8, beats 0x03020100, 0x07060504 -> header words, then data 0x0706050403020100; err=0.
- in_bytes=5, beats 0xAABBCCDD, 0xFFFFFF11 -> third word 0x00000011AABBCCDD; header1 = 0x28.
- in_bytes=16, core_ready toggles 1/0 every cycle -> 4 words in order, each held stable while core_ready=0, s_ready stalls, no loss.
- LEN_CHECK_EN, in_bytes=8, s_last on the first beat 0x11111111 -> data 0x0000000011111111, err=1; next command clears err.
- rst pulsed low during DATA after 1 of 4 beats -> all outputs at reset values asynchronously; a fresh command then sends a complete new header.

Source files
------------

// File: rtl/keccak_stream_adapter.sv
// Feeds the SHAKE core: two header words, then 32-bit beats packed into zero-masked 64-bit words.
// Header latency 1 cycle; beats stall while a packed word waits on core_ready. Option: KECCAK_ADAPTER_LEN_CHECK_EN.
module keccak_stream_adapter #(
  parameter int IN_W = 32,
  parameter int W    = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_mode,
  input  logic [31:0]     cmd_out_bits,
  input  logic [31:0]     cmd_in_bytes,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [IN_W-1:0] s_data,
  input  logic            s_last,
  output logic            core_valid_n,
  input  logic            core_ready,
  output logic [W-1:0]    core_data,
  output logic            busy,
  output logic            err
);

`ifdef KECCAK_ADAPTER_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  localparam int          BSH   = $clog2(IN_W / 8);
  localparam int          WSH   = BSH + 1;
  localparam logic [31:0] REM_B = 32'(IN_W / 8 - 1);
  localparam logic [31:0] REM_W = 32'(W / 8 - 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE} state_t;

  state_t          state;
  logic [31:0]     in_bytes;
  logic [31:0]     words_left;
  logic [31:0]     beats_left;
  logic [IN_W-1:0] lo_dat;
  logic            lo_vld;
  logic            zfill;
  logic            disc;

  logic            in_data, slot_free, xfer, last_beat;
  logic            take_real, take_zero, take, disc_end, words_done;
  logic [31:0]     rem;
  logic [IN_W-1:0] beat_mask, beat;

  assign in_data   = (state == DATA);
  assign slot_free = core_valid_n || core_ready;
  assign xfer      = !core_valid_n && core_ready;
  assign last_beat = (beats_left == 32'd1);
  assign cmd_ready = (state == IDLE);
  assign s_ready   = in_data && (disc || (beats_left != 32'd0 && slot_free && !zfill));
  assign take_real = s_valid && s_ready && (beats_left != 32'd0);
  assign take_zero = in_data && zfill && slot_free && (beats_left != 32'd0);
  assign take      = take_real || take_zero;
  assign disc_end  = disc && s_valid && s_last;
  assign rem       = in_bytes & REM_B;
  // the final word may only finish once any trailing-beat discard has seen s_last
  assign words_done = (xfer && words_left == 32'd1 && (!disc || disc_end)) ||
                      (words_left == 32'd0 && disc_end);

  always_comb begin
    beat_mask = '1;
    if (last_beat && rem != 32'd0) begin
      for (int i = 0; i < IN_W / 8; i++) begin
        if (32'(i) >= rem) beat_mask[i*8 +: 8] = 8'h00;
      end
    end
    beat = take_zero ? '0 : (s_data & beat_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      in_bytes     <= '0;
      words_left   <= '0;
      beats_left   <= '0;
      lo_dat       <= '0;
      lo_vld       <= 1'b0;
      zfill        <= 1'b0;
      disc         <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      core_valid_n <= 1'b1;
      core_data    <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          in_bytes     <= cmd_in_bytes;
          words_left   <= (cmd_in_bytes >> WSH) + {31'b0, |(cmd_in_bytes & REM_W)};
          beats_left   <= (cmd_in_bytes >> BSH) + {31'b0, |(cmd_in_bytes & REM_B)};
          lo_vld       <= 1'b0;
          zfill        <= 1'b0;
          disc         <= 1'b0;
          err          <= 1'b0;
          busy         <= 1'b1;
          core_data    <= W'({cmd_mode, 30'b0, cmd_out_bits});
          core_valid_n <= 1'b0;
          state        <= HDR0;
        end
        HDR0: if (core_ready) begin
          core_data <= W'({29'b0, in_bytes, 3'b0});
          state     <= HDR1;
        end
        HDR1: if (core_ready) begin
          core_valid_n <= 1'b1;
          state        <= (words_left == 32'd0) ? DONE : DATA;
        end
        DATA: begin
          if (xfer) begin
            core_valid_n <= 1'b1;
            words_left   <= words_left - 32'd1;
          end
          if (take) begin
            beats_left <= beats_left - 32'd1;
            if (lo_vld || last_beat) begin
              core_data    <= lo_vld ? {beat, lo_dat} : {{(W-IN_W){1'b0}}, beat};
              core_valid_n <= 1'b0;
              lo_vld       <= 1'b0;
            end else begin
              lo_dat <= beat;
              lo_vld <= 1'b1;
            end
            if (last_beat) zfill <= 1'b0;
          end
          // early s_last pads the rest with zeros; missing s_last drains extra beats
          if (LEN_CHK && take_real && s_last && !last_beat) begin
            zfill <= 1'b1;
            err   <= 1'b1;
          end
          if (LEN_CHK && take_real && !s_last && last_beat) begin
            disc <= 1'b1;
            err  <= 1'b1;
          end
          if (disc_end) disc <= 1'b0;
          if (words_done) state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_stream_adapter.sv
// Scoreboard bench for keccak_stream_adapter: expected core words queued at stimulus time, checked on transfer.
module tb_keccak_stream_adapter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = '0;
  logic [31:0] cmd_out_bits = '0;
  logic [31:0] cmd_in_bytes = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        core_valid_n;
  logic        core_ready = 1'b1;
  logic [63:0] core_data;
  logic        busy;
  logic        err;

  int          n_checks = 0;
  int          n_fail = 0;
  int          hold_seen = 0;
  logic [63:0] sb[$];
  bit          rdy_toggle = 1'b0;
  logic        holding = 1'b0;
  logic [63:0] held = '0;

  keccak_stream_adapter #(.IN_W(32), .W(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_out_bits(cmd_out_bits), .cmd_in_bytes(cmd_in_bytes),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .core_valid_n(core_valid_n), .core_ready(core_ready), .core_data(core_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rdy_toggle) core_ready = ~core_ready;
    else core_ready = 1'b1;
  end

  // Core-side monitor: inputs change 1ns after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (!rst) begin
      holding = 1'b0;
    end else begin
      if (holding) begin
        n_checks++;
        hold_seen++;
        if (core_valid_n !== 1'b0 || core_data !== held) begin
          n_fail++;
          $display("FAIL hold_stable: valid_n=%b data=%h, required valid_n=0 data=%h", core_valid_n, core_data, held);
        end
      end
      holding = !core_valid_n && !core_ready;
      held    = core_data;
      if (!core_valid_n && !core_ready) begin
        n_checks++;
        if (s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL s_ready_stall: s_ready=%b, required 0 while word waits", s_ready);
        end
      end
      if (!core_valid_n && core_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL core_word: got unexpected word %h, required none", core_data);
        end else begin
          logic [63:0] exp;
          exp = sb.pop_front();
          if (core_data !== exp) begin
            n_fail++;
            $display("FAIL core_word: got %h, required %h", core_data, exp);
          end
        end
      end
    end
  end

  task automatic drive_cmd(input logic [1:0] m, input logic [31:0] ob, input logic [31:0] ib);
    int g = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_mode = m; cmd_out_bits = ob; cmd_in_bytes = ib;
    sb.push_back({m, 30'b0, ob});
    sb.push_back({29'b0, ib, 3'b0});
    @(negedge clk);
    while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, g);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_beats(input logic [31:0] d[$], input int last_idx, output int stalls);
    int i = 0;
    int g = 0;
    bit started = 1'b0;
    stalls = 0;
    @(posedge clk); #1;
    while (i < d.size() && g < 2000) begin
      s_valid = 1'b1; s_data = d[i]; s_last = (i == last_idx);
      @(negedge clk);
      if (s_ready) begin started = 1'b1; i++; end
      else if (started) stalls++;
      g++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (i < d.size()) begin
      n_checks++; n_fail++;
      $display("FAIL beat_accept: %0d of %0d beats taken, required all", i, d.size());
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && g < 1000) begin @(negedge clk); g++; end
    if (busy || sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: busy=%b pending=%0d, required 0/0", busy, sb.size());
    end
  endtask

  task automatic push_model(input int ib, input logic [31:0] d[$]);
    for (int w = 0; w < (ib + 7) / 8; w++) begin
      logic [63:0] x;
      x = '0;
      for (int k = 0; k < 8; k++) begin
        int b;
        b = 8 * w + k;
        if (b < ib) x[8*k +: 8] = d[b/4][8*(b%4) +: 8];
      end
      sb.push_back(x);
    end
  endtask

  task automatic check_end(input string name, input logic exp_err);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words pending, required 0", name, sb.size());
    end
    n_checks++;
    if (err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_err: err=%b, required %b", name, err, exp_err);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: %b, required 1", cmd_ready); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: %b, required 0", s_ready); end
    n_checks++; if (core_valid_n !== 1'b1) begin n_fail++; $display("FAIL rst_valid_n: %b, required 1", core_valid_n); end
    n_checks++; if (core_data !== 64'h0) begin n_fail++; $display("FAIL rst_data: %h, required 0", core_data); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_busy_err: %b%b, required 00", busy, err); end
    rst = 1'b1;
  endtask

  task automatic test_empty_msg();
    int n = 0;
    drive_cmd(2'b01, 32'd256, 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    n_checks++;
    if (n != 3) begin n_fail++; $display("FAIL empty_busy_cycles: %0d, required 3", n); end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL empty_cmd_ready: %b, required 1", cmd_ready); end
    check_end("empty", 1'b0);
  endtask

  task automatic test_eight_bytes();
    logic [31:0] q[$];
    int st;
    q = '{32'h03020100, 32'h07060504};
    drive_cmd(2'b00, 32'd256, 32'd8);
    sb.push_back(64'h0706050403020100);
    drive_beats(q, 1, st);
    wait_idle();
    check_end("eight", 1'b0);
  endtask

  task automatic test_partial_mask();
    logic [31:0] q[$];
    int st;
    q = '{32'hAABBCCDD, 32'hFFFFFF11};
    drive_cmd(2'b10, 32'd128, 32'd5);
    sb.push_back(64'h00000011AABBCCDD);
    drive_beats(q, 1, st);
    wait_idle();
    check_end("mask5", 1'b0);
  endtask

  task automatic test_ready_toggle();
    logic [31:0] q[$];
    int st;
    int h0;
    q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    h0 = hold_seen;
    rdy_toggle = 1'b1;
    drive_cmd(2'b11, 32'd512, 32'd16);
    sb.push_back(64'h0706050403020100);
    sb.push_back(64'h0F0E0D0C0B0A0908);
    drive_beats(q, 3, st);
    wait_idle();
    rdy_toggle = 1'b0;
    n_checks++;
    if (hold_seen == h0) begin n_fail++; $display("FAIL toggle_holds: %0d hold cycles seen, required >0", hold_seen - h0); end
    check_end("toggle", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    int st;
    for (int i = 0; i < 6; i++) q.push_back($urandom);
    drive_cmd(2'b01, 32'd64, 32'd24);
    push_model(24, q);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_in_bytes = 32'd0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_cmd_block: cmd_ready=%b busy=%b, required 0/1", cmd_ready, busy);
    end
    drive_beats(q, 5, st);
    cmd_valid = 1'b0;
    n_checks++;
    if (st != 0) begin n_fail++; $display("FAIL b2b_stalls: %0d, required 0", st); end
    wait_idle();
    check_end("b2b", 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [31:0] q[$];
      int ib;
      int st;
      ib = int'($urandom_range(1, 37));
      for (int i = 0; i < (ib + 3) / 4; i++) q.push_back($urandom);
      drive_cmd(2'($urandom_range(0, 3)), $urandom, 32'(ib));
      push_model(ib, q);
      drive_beats(q, q.size() - 1, st);
      wait_idle();
      check_end("random", 1'b0);
    end
  endtask

  task automatic test_len_check();
    logic [31:0] q[$];
    int st;
`ifdef KECCAK_ADAPTER_LEN_CHECK_EN
    q = '{32'h11111111};
    drive_cmd(2'b00, 32'd256, 32'd8);
    sb.push_back(64'h0000000011111111);
    drive_beats(q, 0, st);
    wait_idle();
    check_end("lenchk", 1'b1);
    drive_cmd(2'b00, 32'd256, 32'd0);
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL lenchk_clear: err=%b, required 0", err); end
    wait_idle();
`else
    q = '{32'h11111111, 32'h22222222};
    drive_cmd(2'b00, 32'd256, 32'd8);
    sb.push_back(64'h2222222211111111);
    drive_beats(q, 0, st);
    wait_idle();
    check_end("lenchk_off", 1'b0);
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] q[$];
    int st;
    q = '{32'h03020100};
    drive_cmd(2'b00, 32'd256, 32'd16);
    drive_beats(q, -1, st);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || s_ready !== 1'b0 || core_valid_n !== 1'b1 ||
        core_data !== 64'h0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b s_rdy=%b vn=%b data=%h busy=%b err=%b, required 1 0 1 0 0 0",
               cmd_ready, s_ready, core_valid_n, core_data, busy, err);
    end
    sb.delete();
    @(negedge clk); #2 rst = 1'b1;
    q = '{32'hDEADBEEF};
    drive_cmd(2'b10, 32'd512, 32'd4);
    sb.push_back(64'h00000000DEADBEEF);
    drive_beats(q, 0, st);
    wait_idle();
    check_end("post_reset", 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation ran past limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_empty_msg();
    test_eight_bytes();
    test_partial_mask();
    test_ready_toggle();
    test_back_to_back();
    test_random();
    test_len_check();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
